// File: rtl/calc_pkg.sv
// Shared definitions for the calculator sequencer: funct codes, FSM states, default width.
package calc_pkg;

    localparam int DEFAULT_WIDTH = 16;

    localparam logic [2:0] FN_ADD      = 3'b000;
    localparam logic [2:0] FN_SUB      = 3'b001;
    localparam logic [2:0] FN_ADD_PREV = 3'b100;
    localparam logic [2:0] FN_SUB_PREV = 3'b101;
    localparam logic [2:0] FN_MULT     = 3'b110;
    localparam logic [2:0] FN_DIV      = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        ITER = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/calc_iter_unit.sv
// Iterative shift-add multiplier, plus restoring divider when CALC_DIV_EN is defined.
// done is high during the final step; result/overflow then show the post-step value.
import calc_pkg::*;

module calc_iter_unit #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
`ifdef CALC_DIV_EN
    input  logic             div_mode,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH + 1);

    logic             running;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] hi_nxt;
    logic [WIDTH-1:0] lo_nxt;
`ifdef CALC_DIV_EN
    logic             div_q;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
`endif

    // Multiply: {hi,lo} starts as {0,B}; each step adds A into hi when lo[0] is set, then shifts right.
    always_comb begin
        addend = lo[0] ? opnd : '0;
        sum    = {1'b0, hi} + {1'b0, addend};
        hi_nxt = sum[WIDTH:1];
        lo_nxt = {sum[0], lo[WIDTH-1:1]};
`ifdef CALC_DIV_EN
        // Divide: hi is the partial remainder, lo shifts the dividend out and the quotient in.
        shifted = {hi, lo[WIDTH-1]};
        diff    = shifted - {1'b0, opnd};
        if (div_q) begin
            if (!diff[WIDTH]) begin
                hi_nxt = diff[WIDTH-1:0];
                lo_nxt = {lo[WIDTH-2:0], 1'b1};
            end else begin
                hi_nxt = shifted[WIDTH-1:0];
                lo_nxt = {lo[WIDTH-2:0], 1'b0};
            end
        end
`endif
    end

    assign done   = running && (cnt == CW'(WIDTH - 1));
    assign result = lo_nxt;
`ifdef CALC_DIV_EN
    assign overflow = !div_q && (|hi_nxt);
`else
    assign overflow = |hi_nxt;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            running <= 1'b0;
            cnt     <= '0;
        end else if (start) begin
            running <= 1'b1;
            cnt     <= '0;
        end else if (running) begin
            cnt <= cnt + CW'(1);
            if (done) begin
                running <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            hi <= '0;
`ifdef CALC_DIV_EN
            div_q <= div_mode;
            lo    <= div_mode ? a : b;
            opnd  <= div_mode ? b : a;
`else
            lo   <= b;
            opnd <= a;
`endif
        end else if (running) begin
            hi <= hi_nxt;
            lo <= lo_nxt;
        end
    end

endmodule

// File: rtl/calc_sequencer.sv
// Multi-cycle calculator sequencer: instruction/result handshakes, FSM and prev register.
// Optional divide support is compiled in with CALC_DIV_EN.
import calc_pkg::*;

module calc_sequencer #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [2:0]       funct,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             illegal,
    output logic             busy
);

    state_t           state;
    logic [2:0]       fn_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] prev;

    logic             accept;
    logic             go_iter;
    logic             iter_done;
    logic [WIDTH-1:0] iter_res;
    logic             iter_ovf;

    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             sub;
    logic             arith;
    logic [WIDTH-1:0] exec_res;
    logic             exec_ovf;
    logic             exec_ill;

    function automatic logic arith_ovf(input logic signed [WIDTH-1:0] lhs,
                                       input logic signed [WIDTH-1:0] rhs,
                                       input logic signed [WIDTH-1:0] res,
                                       input logic                    is_sub);
        logic sign_match;
        sign_match = (lhs[WIDTH-1] == rhs[WIDTH-1]);
        return (is_sub ? !sign_match : sign_match) && (res[WIDTH-1] != lhs[WIDTH-1]);
    endfunction

    assign accept = (state == IDLE) && instr_valid;

    always_comb begin
        go_iter = (funct == FN_MULT);
`ifdef CALC_DIV_EN
        // Divide by zero is resolved in one EXEC cycle rather than iterating.
        if (funct == FN_DIV && operandB != '0) begin
            go_iter = 1'b1;
        end
`endif
    end

    calc_iter_unit #(.WIDTH(WIDTH)) u_iter (
        .clk      (clk),
        .reset    (reset),
        .start    (accept && go_iter),
`ifdef CALC_DIV_EN
        .div_mode (funct == FN_DIV),
`endif
        .a        (operandA),
        .b        (operandB),
        .done     (iter_done),
        .result   (iter_res),
        .overflow (iter_ovf)
    );

    always_comb begin
        x        = a_q;
        y        = b_q;
        sub      = 1'b0;
        arith    = 1'b0;
        exec_res = '0;
        exec_ovf = 1'b0;
        exec_ill = 1'b0;
        case (fn_q)
            FN_ADD:      arith = 1'b1;
            FN_SUB:      begin arith = 1'b1; sub = 1'b1; end
            FN_ADD_PREV: begin arith = 1'b1; x = prev; y = a_q; end
            FN_SUB_PREV: begin arith = 1'b1; sub = 1'b1; x = prev; y = a_q; end
`ifdef CALC_DIV_EN
            FN_DIV:      begin exec_res = '1; exec_ovf = 1'b1; end
`endif
            default:     exec_ill = 1'b1;
        endcase
        if (arith) begin
            exec_res = sub ? (x - y) : (x + y);
            exec_ovf = arith_ovf(x, y, exec_res, sub);
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            fn_q <= funct;
            a_q  <= operandA;
            b_q  <= operandB;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            instr_ready <= 1'b1;
            res_valid   <= 1'b0;
            busy        <= 1'b0;
            result      <= '0;
            overflow    <= 1'b0;
            illegal     <= 1'b0;
            prev        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (instr_valid) begin
                        instr_ready <= 1'b0;
                        busy        <= 1'b1;
                        state       <= go_iter ? ITER : EXEC;
                    end
                end
                EXEC: begin
                    result    <= exec_res;
                    overflow  <= exec_ovf;
                    illegal   <= exec_ill;
                    res_valid <= 1'b1;
                    state     <= DONE;
                end
                ITER: begin
                    if (iter_done) begin
                        result    <= iter_res;
                        overflow  <= iter_ovf;
                        illegal   <= 1'b0;
                        res_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        if (!illegal) begin
                            prev <= result;
                        end
                        res_valid   <= 1'b0;
                        instr_ready <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    instr_ready <= 1'b1;
                    res_valid   <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_calc_sequencer.sv
// Table-driven bench for calc_sequencer with a result scoreboard and hand-written corner sequences.
import calc_pkg::*;

module tb_calc_sequencer;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         instr_valid;
    logic         instr_ready;
    logic [2:0]   funct;
    logic [W-1:0] operandA;
    logic [W-1:0] operandB;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] result;
    logic         overflow;
    logic         illegal;
    logic         busy;

    calc_sequencer #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .funct       (funct),
        .operandA    (operandA),
        .operandB    (operandB),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .result      (result),
        .overflow    (overflow),
        .illegal     (illegal),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   fn;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         ovf;
        logic         ill;
        int           lat;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic vec_t mk(input logic [2:0] fn, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] res, input logic ovf, input logic ill, input int lat);
        vec_t v;
        v.fn = fn; v.a = a; v.b = b; v.res = res; v.ovf = ovf; v.ill = ill; v.lat = lat;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Caller is #1 after an edge; returns #1 after the accept edge.
    task automatic issue(input logic [2:0] fn, input logic [W-1:0] a, input logic [W-1:0] b, output bit ok);
        int n;
        instr_valid = 1'b1;
        funct       = fn;
        operandA    = a;
        operandB    = b;
        n = 0;
        while (!instr_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        ok = instr_ready;
        if (!ok) begin
            instr_valid = 1'b0;
            chk("accept_timeout", 32'd0, 32'd1);
            return;
        end
        @(posedge clk); #1;
        instr_valid = 1'b0;
        funct       = 3'($urandom);
        operandA    = W'($urandom);
        operandB    = W'($urandom);
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!res_valid && lat < 100);
    endtask

    task automatic compare_pop(input string tag, input int lat);
        vec_t e;
        e = sb.pop_front();
        chk({tag, "_result"}, 32'(result), 32'(e.res));
        chk({tag, "_overflow"}, 32'(overflow), 32'(e.ovf));
        chk({tag, "_illegal"}, 32'(illegal), 32'(e.ill));
        chk({tag, "_latency"}, 32'(lat), 32'(e.lat));
    endtask

    task automatic release_result(input string tag);
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        chk({tag, "_released"}, 32'(res_valid), 32'd0);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        bit ok;
        int lat;
        sb.push_back(v);
        issue(v.fn, v.a, v.b, ok);
        if (!ok) begin
            void'(sb.pop_front());
            return;
        end
        wait_result(lat);
        compare_pop(tag, lat);
        release_result(tag);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int lat;

        reset       = 1'b1;
        instr_valid = 1'b0;
        res_ready   = 1'b0;
        funct       = '0;
        operandA    = '0;
        operandB    = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        chk("rst_instr_ready", 32'(instr_ready), 32'd1);
        chk("rst_res_valid",   32'(res_valid),   32'd0);
        chk("rst_busy",        32'(busy),        32'd0);
        chk("rst_result",      32'(result),      32'd0);
        chk("rst_overflow",    32'(overflow),    32'd0);
        chk("rst_illegal",     32'(illegal),     32'd0);

        vecs.push_back(mk(FN_ADD,      16'd5,    16'd7,    16'd12,   1'b0, 1'b0, 1));
        vecs.push_back(mk(FN_ADD_PREV, 16'd3,    16'hAAAA, 16'd15,   1'b0, 1'b0, 1));
        vecs.push_back(mk(FN_SUB_PREV, 16'd20,   16'h5555, 16'hFFFB, 1'b0, 1'b0, 1));
        vecs.push_back(mk(FN_SUB,      16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b0, 1));
        vecs.push_back(mk(FN_ADD,      16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b0, 1));
        vecs.push_back(mk(FN_MULT,     16'd300,  16'd200,  16'hEA60, 1'b0, 1'b0, 16));
        vecs.push_back(mk(FN_MULT,     16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b0, 16));
        vecs.push_back(mk(FN_ADD,      16'h1234, 16'h0000, 16'h1234, 1'b0, 1'b0, 1));
        vecs.push_back(mk(3'b010,      16'd5,    16'd6,    16'h0000, 1'b0, 1'b1, 1));
        vecs.push_back(mk(FN_ADD_PREV, 16'd0,    16'h0F0F, 16'h1234, 1'b0, 1'b0, 1));
        vecs.push_back(mk(3'b011,      16'd9,    16'd9,    16'h0000, 1'b0, 1'b1, 1));
`ifndef CALC_DIV_EN
        vecs.push_back(mk(FN_DIV,      16'd100,  16'd7,    16'h0000, 1'b0, 1'b1, 1));
`endif
        vecs.push_back(mk(FN_SUB_PREV, 16'h0234, 16'h0000, 16'h1000, 1'b0, 1'b0, 1));
        vecs.push_back(mk(FN_ADD_PREV, 16'h7000, 16'h0000, 16'h8000, 1'b1, 1'b0, 1));
        vecs.push_back(mk(FN_SUB_PREV, 16'h0001, 16'h0000, 16'h7FFF, 1'b1, 1'b0, 1));
`ifdef CALC_DIV_EN
        vecs.push_back(mk(FN_DIV,      16'd100,  16'd7,    16'd14,   1'b0, 1'b0, 16));
        vecs.push_back(mk(FN_DIV,      16'd5,    16'd0,    16'hFFFF, 1'b1, 1'b0, 1));
        vecs.push_back(mk(FN_ADD_PREV, 16'd0,    16'd0,    16'hFFFF, 1'b0, 1'b0, 1));
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i], $sformatf("v%0d", i));
        end

        // Backpressure: result held, queued instruction refused, prev written only on transfer.
        sb.push_back(mk(FN_ADD, 16'd10, 16'd20, 16'd30, 1'b0, 1'b0, 1));
        issue(FN_ADD, 16'd10, 16'd20, ok);
        if (ok) begin
            wait_result(lat);
            instr_valid = 1'b1;
            funct       = FN_ADD;
            operandA    = 16'd1;
            operandB    = 16'd1;
            for (int c = 0; c < 5; c++) begin
                @(posedge clk); #1;
                chk($sformatf("stall%0d_result", c),      32'(result),      32'd30);
                chk($sformatf("stall%0d_instr_ready", c), 32'(instr_ready), 32'd0);
                chk($sformatf("stall%0d_res_valid", c),   32'(res_valid),   32'd1);
                chk($sformatf("stall%0d_busy", c),        32'(busy),        32'd1);
            end
            instr_valid = 1'b0;
            compare_pop("stall", lat);
            release_result("stall");
        end else begin
            void'(sb.pop_front());
        end
        run_vec(mk(FN_ADD_PREV, 16'd0, 16'd0, 16'd30, 1'b0, 1'b0, 1), "stall_prev");

        // Reset in the middle of a multiply.
        issue(FN_MULT, 16'd300, 16'd200, ok);
        repeat (7) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midrst_busy",        32'(busy),        32'd0);
        chk("midrst_instr_ready", 32'(instr_ready), 32'd1);
        chk("midrst_res_valid",   32'(res_valid),   32'd0);
        chk("midrst_result",      32'(result),      32'd0);
        run_vec(mk(FN_ADD_PREV, 16'd0, 16'd0, 16'd0, 1'b0, 1'b0, 1), "midrst_prev");
        run_vec(mk(FN_MULT, 16'hFFFF, 16'd2, 16'hFFFE, 1'b1, 1'b0, 16), "mult_after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
